uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side buffer that sits directly downstream of the UART receiver FSM. It captures each byte on the receiver's one-cycle done tick and holds up to 16 bytes until the processor consumes them. The processor reads bytes via UARTrd and polls the packed status byte via UARTstat (accumulator mux selections UartData/UartStat). The block also tracks fill level and a sticky overrun flag for bytes lost when the buffer is full.

Parameters:
DATA_BITS, 8, width of each received byte (matches receiver dOut)
FIFO_DEPTH, 16, number of storage entries; must be a power of 2
ADDR_W, 4, pointer width = log2(FIFO_DEPTH)
CNT_W, 5, occupancy counter width = ADDR_W+1

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
wrTick  input  1  one-cycle write strobe, driven by receiver rxDoneTick
wrData  input  DATA_BITS  received byte, driven by receiver dOut, sampled when wrTick=1
rdReq  input  1  one-cycle pop request from processor (UARTrd)
clrOverrun  input  1  one-cycle clear of sticky overrun flag
rdData  output  DATA_BITS  registered popped byte, held until next successful pop
rdValid  output  1  one-cycle pulse, rdData updated this cycle
empty  output  1  count==0
full  output  1  count==FIFO_DEPTH
count  output  CNT_W  current occupancy 0..16
overrun  output  1  sticky: a byte was dropped because the buffer was full
status  output  8  {overrun, full, empty, count[4:0]} for UARTstat

Behaviour:
- Reset (reset=0, asynchronous): wrPtr=0, rdPtr=0, count=0, rdData=0, rdValid=0, overrun=0. This gives empty=1, full=0, status=8'h20. Storage contents are not reset.
- Write accepted when wrTick=1 and (count<FIFO_DEPTH or a pop is accepted in the same cycle). On accept: mem[wrPtr]<=wrData and wrPtr<=wrPtr+1 (wraps modulo 16).
- Pop accepted when rdReq=1 and count>0. On accept: rdData<=mem[rdPtr], rdPtr<=rdPtr+1 (wraps), rdValid=1 on the next cycle. Latency is 1 clk from rdReq to rdValid/rdData.
- rdReq while empty: ignored. rdData holds, rdValid stays 0, no flag is set.
- Simultaneous write and pop:
  - Not empty (including full): both are accepted and count is unchanged. When full, the freed slot is reused and overrun is not set.
  - Empty: the write is accepted, the pop is ignored, count becomes 1. Write data is never bypassed to rdData.
- wrTick while full with no pop: byte is dropped, pointers and count are unchanged, overrun<=1.
- clrOverrun: overrun<=0. If an overrun event occurs in the same cycle, set wins and overrun stays 1.
- count: +1 on write only, -1 on pop only, unchanged for both or neither. It never exceeds 16 or goes below 0.
- empty, full and status are combinational from registered count and overrun. They update in the cycle after the event.
- Reset mid-operation: all state clears immediately. Any in-flight rdValid pulse is killed.

Decomposition:
- Shared package uart_pkg: DATA_BITS, FIFO_DEPTH, ADDR_W, CNT_W, and status bit positions (STAT_OVR=7, STAT_FULL=6, STAT_EMPTY=5, STAT_CNT_LSB=0).
- The 8-bit UART data width and 16-entry FIFO depth (dataBits, fifoDepth, fifoCntrWidth) come from this package for both receiver and FIFO.
- One sub-module: uart_fifo_mem, a 16x8 register file with one synchronous write port and one asynchronous read port. Pointers, count and flags stay in uart_rx_fifo.

Test Plan:
1. Reset: assert reset=0 mid-run -> count=0, empty=1, rdValid=0, overrun=0, status=8'h20 immediately, before any clk edge.
2. Single byte: wrTick with wrData=8'hA5, then rdReq two cycles later -> count 0->1->0; rdValid pulses 1 cycle after rdReq with rdData=8'hA5; empty returns to 1.
3. Fill and wrap: write 8'h00..8'h0F (full=1, count=16, status=8'h50); pop 4; write 8'h10..8'h13; pop 16 -> order 04..0F then 10..13, pointers wrapped, empty=1.
4. Overrun: with full, wrTick wrData=8'hEE and no rdReq -> byte dropped, count stays 16, overrun=1 (status=8'hD0). Pulse clrOverrun -> overrun=0. clrOverrun coincident with a new drop -> overrun=1.
5. Simultaneous at full: count=16, wrTick=1 with 8'h77 and rdReq=1 same cycle -> count stays 16, overrun stays 0, oldest byte returned; 8'h77 is the last byte read out after draining.
6. Boundary pops: rdReq while empty -> rdValid=0, rdData unchanged. wrTick(8'h3C)+rdReq same cycle while empty -> count=1, rdValid=0; next rdReq returns 8'h3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: data width, RX FIFO geometry and status byte layout.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned ADDR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = ADDR_W + 1;

  // Bit positions inside the UARTstat byte.
  localparam int unsigned STAT_OVR     = 7;
  localparam int unsigned STAT_FULL    = 6;
  localparam int unsigned STAT_EMPTY   = 5;
  localparam int unsigned STAT_CNT_LSB = 0;

  // Pack flags and occupancy into the processor-visible status byte.
  function automatic logic [7:0] pack_status(input logic             ovr,
                                             input logic             full,
                                             input logic             empty,
                                             input logic [CNT_W-1:0] cnt);
    logic [7:0] s;
    s                          = '0;
    s[STAT_OVR]                = ovr;
    s[STAT_FULL]               = full;
    s[STAT_EMPTY]              = empty;
    s[STAT_CNT_LSB +: CNT_W]   = cnt;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-file storage for the RX FIFO: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem
  import uart_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// 16-entry receive buffer between the UART receiver and the processor.
// Captures bytes on the receiver done tick, returns them one cycle after a
// pop request, and tracks occupancy plus a sticky overrun flag.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_tick_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic                 rd_req_i,
  input  logic                 clr_overrun_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 rd_valid_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 overrun_o,
  output logic [7:0]           status_o
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 overrun_q, overrun_d;

  logic                 is_empty, is_full;
  logic                 pop_ok, wr_ok, drop;
  logic [DATA_BITS-1:0] mem_rdata;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FullCnt);

  // A pop frees a slot in the same cycle, so a write at full still lands.
  assign pop_ok = rd_req_i && !is_empty;
  assign wr_ok  = wr_tick_i && (!is_full || pop_ok);
  assign drop   = wr_tick_i && is_full && !pop_ok;

  uart_fifo_mem u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state for pointers, occupancy, read data and overrun flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = pop_ok;
    overrun_d  = overrun_q;

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem_rdata;
    end

    unique case ({wr_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new drop wins over a coincident clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign empty_o    = is_empty;
  assign full_o     = is_full;
  assign count_o    = count_q;
  assign overrun_o  = overrun_q;
  assign status_o   = pack_status(overrun_q, is_full, is_empty, count_q);

endmodule
